popcount_stream: RTL and testbench
==================================

Name: popcount_stream

Overview:
- Pipelined, parametrised successor to the combinational count-ones block.
- Accepts a stream of DATA_WIDTH-bit words with a valid/ready handshake and returns, per word, the number of ones or zeros (selectable per beat).
- Also returns a saturating running total across a packet delimited by din_last.
- Sits between a packet source and any statistics/CRC-style consumer that needs bit-density metrics.

Parameters:
- DATA_WIDTH, 16, input word width in bits; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 4, bits counted per stage-1 partial counter.
- ACC_WIDTH, 16, width of the packet running-total accumulator.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_WIDTH  data word.
- din_mode  input  1  0 = count ones, 1 = count zeros; sampled with the beat.
- din_last  input  1  marks the final word of a packet.
- din_valid  input  1  source has a word.
- din_ready  output  1  block accepts the word this cycle.
- dout_count  output  $clog2(DATA_WIDTH)+1  per-word count.
- dout_total  output  ACC_WIDTH  running packet total including this word.
- dout_sat  output  1  dout_total has saturated within the current packet.
- dout_last  output  1  delayed din_last.
- dout_valid  output  1  output beat valid.
- dout_ready  input  1  sink accepts the beat.

Behaviour:
- Reset (async assert, sync release): all outputs 0; stage valids v1 = v2 = 0; accumulator 0; sat flag 0.
- Transfer occurs on any edge where valid && ready, on both the din and dout sides.
- Two-stage pipeline with global advance:
  - adv2 = !v2 || dout_ready
  - adv1 = !v1 || adv2
  - din_ready = adv1, a combinational path from dout_ready.
- Stage 1:
  - on adv1, capture v1 <= din_valid, plus last and mode.
  - Capture DATA_WIDTH/CHUNK_WIDTH partial counts of (mode ? ~din : din).
- Stage 2:
  - on adv2, capture v2 <= v1.
  - Sum the partials into dout_count.
  - Update the accumulator.
- Latency: a word accepted at edge N presents dout_valid at edge N+2 with no stall. Throughput is 1 word/cycle.
- Stall: while dout_valid && !dout_ready, all dout_* hold stable and nothing in stage 2 changes.
- Counts: mode 0 gives popcount(din) in the range 0..DATA_WIDTH; mode 1 gives DATA_WIDTH - popcount(din). An all-ones word in mode 0 yields DATA_WIDTH exactly, so no truncation.
- Accumulator, on a stage-2 capture of a valid beat:
  - sum = acc + count.
  - If sum > 2^ACC_WIDTH-1: dout_total = all ones and dout_sat = 1.
  - dout_sat is sticky for the rest of the packet.
  - acc <= dout_total.
  - If the beat has last=1, acc and the sticky flag clear to 0 after it, so the next beat starts a fresh packet.
- Bubble handling: a bubble (v1 = 0) captured into stage 2 leaves acc, sat, and all dout_* data fields unchanged; only dout_valid deasserts.
- Single-word packet (last on first beat): dout_total = dout_count and dout_last = 1.
- Mode may change beat to beat inside a packet; the total sums the per-beat counts as computed.
- Reset mid-packet drops all in-flight beats, clears the accumulator, and produces no partial output.

Optional Feature:
- Macro: POPCOUNT_PARITY_EN.
- When defined:
  - Adds output port dout_parity (1 bit) = XOR of the selected-polarity word, i.e. dout_count[0].
  - It is registered alongside dout_count, has reset value 0, and holds during stall.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then stream din = 3, 5, 8 (mode 0, last on 8, dout_ready = 1) -> dout_count 2, 2, 1; dout_total 2, 4, 5; dout_last only on the third beat; first dout_valid 2 cycles after first accept.
- din = 16'hFFFF mode 0 then 16'h0000 mode 1, last on second -> counts 16, 16; totals 16, 32; a next packet starting with din = 1 gives total 1.
- Hold dout_ready = 0 for 4 cycles with 3 words offered -> din_ready drops after 2 accepts; outputs stable; after release, 3 beats emerge in order with no loss or duplication.
- ACC_WIDTH = 5: packet of three 16'hFFFF mode-0 words -> totals 16, 31 (sat = 1), 31 (sat = 1); next packet's first beat has sat = 0.
- Assert rst_n low mid-packet with 2 beats in flight -> all dout_* = 0 immediately; after release, a new word 16'h00F0 yields count 4, total 4.
- With POPCOUNT_PARITY_EN: din = 16'h0007 -> dout_parity = 1; din = 16'h0003 -> 0.

Source files
------------

// File: rtl/popcount_stream_if.sv
// popcount_stream_if: stream handshake bundle; POPCOUNT_PARITY_EN adds dout_parity
interface popcount_stream_if #(parameter int DATA_WIDTH = 16, parameter int ACC_WIDTH = 16);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  logic [DATA_WIDTH-1:0] din;
  logic din_mode, din_last, din_valid, din_ready;
  logic [CW-1:0] dout_count;
  logic [ACC_WIDTH-1:0] dout_total;
  logic dout_sat, dout_last, dout_valid, dout_ready;
`ifdef POPCOUNT_PARITY_EN
  logic dout_parity;
`endif
  modport master (
    output din, din_mode, din_last, din_valid, dout_ready,
    input din_ready, dout_count, dout_total, dout_sat, dout_last, dout_valid
`ifdef POPCOUNT_PARITY_EN
    , input dout_parity
`endif
  );
  modport slave (
    input din, din_mode, din_last, din_valid, dout_ready,
    output din_ready, dout_count, dout_total, dout_sat, dout_last, dout_valid
`ifdef POPCOUNT_PARITY_EN
    , output dout_parity
`endif
  );
endinterface

// File: rtl/popcount_stream.sv
// popcount_stream: 2-stage ones/zeros counter with saturating packet total; POPCOUNT_PARITY_EN adds dout_parity
module popcount_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int CHUNK_WIDTH = 4,
  parameter int ACC_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  popcount_stream_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam int NCH = DATA_WIDTH / CHUNK_WIDTH;
  localparam int PW = $clog2(CHUNK_WIDTH) + 1;
  logic v1, v2, last1, adv1, adv2, sat, sat_n, ovf, sat_q, last_q;
  logic [NCH-1:0][PW-1:0] part, part1;
  logic [DATA_WIDTH-1:0] sel;
  logic [CW-1:0] cnt, count_q;
  logic [ACC_WIDTH:0] sum;
  logic [ACC_WIDTH-1:0] acc, tot, total_q;
  assign adv2 = !v2 || bus.dout_ready;
  assign adv1 = !v1 || adv2;
  assign bus.din_ready = adv1;
  assign bus.dout_valid = v2;
  assign bus.dout_count = count_q;
  assign bus.dout_total = total_q;
  assign bus.dout_sat = sat_q;
  assign bus.dout_last = last_q;
  // per-chunk partial counts of the polarity-selected word
  always_comb begin
    part = '0;
    sel = bus.din_mode ? ~bus.din : bus.din;
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < CHUNK_WIDTH; b++)
        part[c] = part[c] + PW'(sel[c*CHUNK_WIDTH+b]);
  end
  // sum partials and form the saturating packet total
  always_comb begin
    cnt = '0;
    for (int c = 0; c < NCH; c++) cnt = cnt + CW'(part1[c]);
    sum = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(cnt);
    ovf = sum[ACC_WIDTH];
    tot = ovf ? '1 : sum[ACC_WIDTH-1:0];
    sat_n = sat | ovf;
  end
  // stage 1: capture beat valid, last flag and partial counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      last1 <= 1'b0;
      part1 <= '0;
    end else if (adv1) begin
      v1 <= bus.din_valid;
      last1 <= bus.din_last;
      part1 <= part;
    end
  end
  // stage 2: register outputs and accumulate; bubbles only drop dout_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      count_q <= '0;
      total_q <= '0;
      sat_q <= 1'b0;
      last_q <= 1'b0;
      acc <= '0;
      sat <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        count_q <= cnt;
        total_q <= tot;
        sat_q <= sat_n;
        last_q <= last1;
        acc <= last1 ? '0 : tot;
        sat <= last1 ? 1'b0 : sat_n;
      end
    end
  end
`ifdef POPCOUNT_PARITY_EN
  logic parity_q;
  assign bus.dout_parity = parity_q;
  // parity of the selected-polarity word is the count's lsb
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else if (adv2 && v1) parity_q <= cnt[0];
  end
`endif
endmodule

// File: tb/tb_popcount_stream.sv
// tb_popcount_stream: randomized scoreboard bench for popcount_stream (define POPCOUNT_PARITY_EN to check parity)
module tb_popcount_stream;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int CW = $clog2(DW) + 1;
  typedef struct {
    int c;
    int t;
    int s;
    int l;
    int p;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  bit hold = 0;
  bit rand_bp = 0;
  int vectors = 0;
  int fails = 0;
  int m_acc = 0;
  int m_sat = 0;
  exp_t exp_q[$];
  popcount_stream_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus();
  popcount_stream #(.DATA_WIDTH(DW), .CHUNK_WIDTH(4), .ACC_WIDTH(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // sink: drive dout_ready just after each rising edge
  always @(posedge clk) begin
    #1;
    bus.dout_ready = hold ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
  end
  // reference model: per-word count from $countones, packet total clamped at 2^AW-1
  task automatic push(input logic [DW-1:0] d, input logic m, input logic l,
                      input bit cc, input int ec, input int et, input int es);
    exp_t e;
    logic [DW-1:0] w;
    int c, s, tot, mx;
    w = m ? ~d : d;
    c = $countones(w);
    mx = (1 << AW) - 1;
    s = m_acc + c;
    if (s > mx) begin
      tot = mx;
      m_sat = 1;
    end else tot = s;
    e.c = cc ? ec : c;
    e.t = cc ? et : tot;
    e.s = cc ? es : m_sat;
    e.l = int'(l);
    e.p = c % 2;
    exp_q.push_back(e);
    m_acc = l ? 0 : tot;
    if (l) m_sat = 0;
  endtask
  task automatic send(input logic [DW-1:0] d, input logic m, input logic l,
                      input bit cc = 0, input int ec = 0, input int et = 0, input int es = 0);
    int t = 0;
    @(negedge clk);
    bus.din = d;
    bus.din_mode = m;
    bus.din_last = l;
    bus.din_valid = 1'b1;
    while (!bus.din_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.din_ready) begin
      chk("accept_timeout", 0, 1);
      bus.din_valid = 1'b0;
      return;
    end
    push(d, m, l, cc, ec, et, es);
    @(posedge clk);
    #1 bus.din_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    rand_bp = 0;
    hold = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
  endtask
  // monitor: compare each transferred beat, and check outputs hold while stalled
  bit prev_stall = 0;
  int snap_c, snap_t, snap_s, snap_l;
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", int'(bus.dout_valid), 1);
        chk("stall_count", int'(bus.dout_count), snap_c);
        chk("stall_total", int'(bus.dout_total), snap_t);
        chk("stall_sat", int'(bus.dout_sat), snap_s);
        chk("stall_last", int'(bus.dout_last), snap_l);
      end
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("count", int'(bus.dout_count), e.c);
          chk("total", int'(bus.dout_total), e.t);
          chk("sat", int'(bus.dout_sat), e.s);
          chk("last", int'(bus.dout_last), e.l);
`ifdef POPCOUNT_PARITY_EN
          chk("parity", int'(bus.dout_parity), e.p);
`endif
        end
      end
      prev_stall = bus.dout_valid && !bus.dout_ready;
      snap_c = int'(bus.dout_count);
      snap_t = int'(bus.dout_total);
      snap_s = int'(bus.dout_sat);
      snap_l = int'(bus.dout_last);
    end
  end
  task automatic chk_zero(input string n);
    chk({n, "_valid"}, int'(bus.dout_valid), 0);
    chk({n, "_count"}, int'(bus.dout_count), 0);
    chk({n, "_total"}, int'(bus.dout_total), 0);
    chk({n, "_sat"}, int'(bus.dout_sat), 0);
    chk({n, "_last"}, int'(bus.dout_last), 0);
  endtask
  logic [DW-1:0] sw[3];
  int acc_n;
  initial begin
    bus.din = '0;
    bus.din_mode = 0;
    bus.din_last = 0;
    bus.din_valid = 0;
    bus.dout_ready = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    // basic packet plus first-beat latency
    fork
      begin
        send(16'd3, 0, 0, 1, 2, 2, 0);
        send(16'd5, 0, 0, 1, 2, 4, 0);
        send(16'd8, 0, 1, 1, 1, 5, 0);
      end
      begin
        int t = 0;
        while (bus.din_valid !== 1'b1 && t < 100) begin
          #1;
          t++;
        end
        @(posedge clk);
        #1 chk("lat_edge1", int'(bus.dout_valid), 0);
        @(posedge clk);
        #1 chk("lat_edge2", int'(bus.dout_valid), 1);
      end
    join
    // full-width counts in both polarities, then a fresh packet
    send(16'hFFFF, 0, 0, 1, 16, 16, 0);
    send(16'h0000, 1, 1, 1, 16, 32, 0);
    send(16'h0001, 0, 1, 1, 1, 1, 0);
    drain();
    // backpressure: only two words fit while the sink stalls
    sw[0] = 16'h000F;
    sw[1] = 16'h00FF;
    sw[2] = 16'h0FFF;
    hold = 1;
    @(posedge clk);
    #2;
    acc_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.din_valid = acc_n < 3;
      bus.din = sw[acc_n < 3 ? acc_n : 2];
      bus.din_mode = 0;
      bus.din_last = acc_n == 2;
      if (bus.din_ready && acc_n < 3) begin
        push(sw[acc_n], 0, acc_n == 2, 1, 4 * (acc_n + 1), acc_n == 0 ? 4 : (acc_n == 1 ? 12 : 24), 0);
        acc_n++;
      end
      @(posedge clk);
    end
    #1;
    chk("stall_accepts", acc_n, 2);
    chk("stall_din_ready", int'(bus.din_ready), 0);
    hold = 0;
    for (int i = acc_n; i < 3; i++)
      send(sw[i], 0, i == 2, 1, 4 * (i + 1), i == 0 ? 4 : (i == 1 ? 12 : 24), 0);
    drain();
    // saturation over a long all-ones packet; sat clears for the next packet
    for (int k = 1; k <= 4097; k++)
      send(16'hFFFF, 0, k == 4097, k >= 4095, 16, k == 4095 ? 65520 : 65535, k >= 4096 ? 1 : 0);
    send(16'h0001, 0, 1, 1, 1, 1, 0);
    drain();
    // reset mid-packet with two beats in flight
    send(16'h1234, 0, 0);
    send(16'h5678, 1, 0);
    rst_n = 0;
    #1 chk_zero("midreset");
    exp_q.delete();
    m_acc = 0;
    m_sat = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    send(16'h00F0, 0, 1, 1, 4, 4, 0);
    // parity words
    send(16'h0007, 0, 0);
    send(16'h0003, 0, 1);
    drain();
    // random stream with random backpressure
    rand_bp = 1;
    repeat (400) send(16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
